// File: rtl/game_pkg.sv
// Shared game-phase and scoring definitions for the frame-clock domain.
// Imported by the round sequencer, HUD and player blocks.
package game_pkg;

   localparam int unsigned PHASE_W = 3;
   localparam int unsigned WIN_W   = 2;
   localparam int unsigned ROUND_W = 2;
   localparam int unsigned FRAME_W = 6;
   localparam int unsigned SECS_W  = 7;
   localparam int unsigned END_W   = 8;

   typedef enum logic [PHASE_W-1:0] {
      PH_MENU      = 3'd0,
      PH_CD_ARM    = 3'd1,
      PH_CD_RUN    = 3'd2,
      PH_FIGHT     = 3'd3,
      PH_ROUND_END = 3'd4,
      PH_MATCH_END = 3'd5
   } phase_e;

   typedef enum logic [WIN_W-1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2,
      WIN_DRAW = 2'd3
   } winner_e;

   typedef struct packed {
      logic [ROUND_W-1:0] p1_wins;
      logic [ROUND_W-1:0] p2_wins;
      winner_e            round_winner;
   } score_t;

   // Win counters saturate rather than wrap.
   function automatic logic [ROUND_W-1:0] sat_inc(input logic [ROUND_W-1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   function automatic winner_e match_result(input logic [ROUND_W-1:0] p1,
                                            input logic [ROUND_W-1:0] p2);
      if (p1 > p2) return WIN_P1;
      if (p2 > p1) return WIN_P2;
      return WIN_DRAW;
   endfunction

endpackage

// File: rtl/round_timer.sv
// Round clock: frame divider feeding a saturating seconds down-counter.
// expire_c flags the wrap that takes the last second to zero.
module round_timer
   import game_pkg::*;
#(
   parameter int unsigned ROUND_SECS     = 60,
   parameter int unsigned FRAMES_PER_SEC = 60
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              enable,
   output logic [SECS_W-1:0] secs_left,
   output logic              expire_c
);

   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [SECS_W-1:0]  secs_q, secs_d;
   logic               wrap_c;

   assign wrap_c   = enable && (frame_q == FRAME_W'(FRAMES_PER_SEC - 1));
   assign expire_c = !load && wrap_c && (secs_q == SECS_W'(1));

   always_comb begin
      frame_d = frame_q;
      secs_d  = secs_q;
      if (load) begin
         frame_d = '0;
         secs_d  = SECS_W'(ROUND_SECS);
      end else if (enable) begin
         if (wrap_c) begin
            frame_d = '0;
            if (secs_q != '0) secs_d = secs_q - SECS_W'(1);
         end else begin
            frame_d = frame_q + FRAME_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= '0;
         secs_q  <= SECS_W'(ROUND_SECS);
      end else begin
         frame_q <= frame_d;
         secs_q  <= secs_d;
      end
   end

   assign secs_left = secs_q;

endmodule

// File: rtl/round_controller.sv
// Match sequencer: menu, countdown handshake, fight, round-end hold, match end.
// Scores KO events into round/match winners; all outputs are registered.
module round_controller
   import game_pkg::*;
#(
   parameter int unsigned ROUND_SECS     = 60,
   parameter int unsigned FRAMES_PER_SEC = 60,
   parameter int unsigned WINS_NEEDED    = 2,
   parameter int unsigned MAX_ROUNDS     = 3,
   parameter int unsigned END_FRAMES     = 120
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               cd_active,
   input  logic               p1_ko,
   input  logic               p2_ko,
   output logic               cd_start,
   output logic [PHASE_W-1:0] phase,
   output logic               fight_en,
   output logic [ROUND_W-1:0] round_num,
   output logic [ROUND_W-1:0] p1_wins,
   output logic [ROUND_W-1:0] p2_wins,
   output logic [SECS_W-1:0]  secs_left,
   output logic [WIN_W-1:0]   round_winner,
   output logic [WIN_W-1:0]   match_winner
);

   phase_e             state_q, state_d;
   logic [ROUND_W-1:0] round_q, round_d;
   score_t             score_q, score_d;
   winner_e            match_winner_q, match_winner_d;
   logic [END_W-1:0]   end_cnt_q, end_cnt_d;
   logic               cd_start_q, cd_start_d;
   logic               fight_en_q, fight_en_d;
   logic               timer_load_c;
   logic               timer_en_c;
   logic               expire_c;
   logic               match_over_c;

   assign timer_load_c = (state_q == PH_CD_RUN) && !cd_active;
   assign timer_en_c   = (state_q == PH_FIGHT);
   assign match_over_c = (score_q.p1_wins == ROUND_W'(WINS_NEEDED))
                      || (score_q.p2_wins == ROUND_W'(WINS_NEEDED))
                      || (round_q == ROUND_W'(MAX_ROUNDS));

   round_timer #(
      .ROUND_SECS     (ROUND_SECS),
      .FRAMES_PER_SEC (FRAMES_PER_SEC)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (timer_load_c),
      .enable    (timer_en_c),
      .secs_left (secs_left),
      .expire_c  (expire_c)
   );

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      score_d        = score_q;
      end_cnt_d      = end_cnt_q;
      match_winner_d = WIN_NONE;
      cd_start_d     = 1'b0;
      fight_en_d     = 1'b0;

      case (state_q)
         PH_MENU: begin
            if (start) state_d = PH_CD_ARM;
         end
         PH_CD_ARM: begin
            state_d = PH_CD_RUN;
         end
         PH_CD_RUN: begin
            if (!cd_active) state_d = PH_FIGHT;
         end
         PH_FIGHT: begin
            // KO outcomes outrank the timeout; a simultaneous double KO is a draw.
            if (p1_ko && p2_ko) begin
               score_d.round_winner = WIN_DRAW;
               state_d              = PH_ROUND_END;
            end else if (p1_ko) begin
               score_d.p2_wins      = sat_inc(score_q.p2_wins);
               score_d.round_winner = WIN_P2;
               state_d              = PH_ROUND_END;
            end else if (p2_ko) begin
               score_d.p1_wins      = sat_inc(score_q.p1_wins);
               score_d.round_winner = WIN_P1;
               state_d              = PH_ROUND_END;
            end else if (expire_c) begin
               score_d.round_winner = WIN_DRAW;
               state_d              = PH_ROUND_END;
            end
            if (state_d == PH_ROUND_END) end_cnt_d = '0;
         end
         PH_ROUND_END: begin
            if (end_cnt_q == END_W'(END_FRAMES - 1)) begin
               if (match_over_c) begin
                  state_d = PH_MATCH_END;
               end else begin
                  round_d = round_q + ROUND_W'(1);
                  state_d = PH_CD_ARM;
               end
            end else begin
               end_cnt_d = end_cnt_q + END_W'(1);
            end
         end
         PH_MATCH_END: begin
            if (start) state_d = PH_MENU;
         end
         default: begin
            state_d = PH_MENU;
         end
      endcase

      // Scores are cleared on the edge that enters the menu and held clear there.
      if (state_d == PH_MENU) begin
         round_d = ROUND_W'(1);
         score_d = '0;
      end

      cd_start_d = (state_d == PH_CD_ARM);
      fight_en_d = (state_d == PH_FIGHT);
      if (state_d == PH_MATCH_END)
         match_winner_d = match_result(score_d.p1_wins, score_d.p2_wins);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= PH_MENU;
         round_q        <= ROUND_W'(1);
         score_q        <= '0;
         match_winner_q <= WIN_NONE;
         end_cnt_q      <= '0;
         cd_start_q     <= 1'b0;
         fight_en_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         round_q        <= round_d;
         score_q        <= score_d;
         match_winner_q <= match_winner_d;
         end_cnt_q      <= end_cnt_d;
         cd_start_q     <= cd_start_d;
         fight_en_q     <= fight_en_d;
      end
   end

   assign phase        = state_q;
   assign cd_start     = cd_start_q;
   assign fight_en     = fight_en_q;
   assign round_num    = round_q;
   assign p1_wins      = score_q.p1_wins;
   assign p2_wins      = score_q.p2_wins;
   assign round_winner = score_q.round_winner;
   assign match_winner = match_winner_q;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: randomized rounds driven through a behavioural
// match model that is compared against every DUT output each cycle.
module tb_round_controller;

   localparam int RS  = 60;
   localparam int FPS = 60;
   localparam int WN  = 2;
   localparam int MR  = 3;
   localparam int EF  = 120;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       cd_active;
   logic       p1_ko;
   logic       p2_ko;
   logic       cd_start;
   logic [2:0] phase;
   logic       fight_en;
   logic [1:0] round_num;
   logic [1:0] p1_wins;
   logic [1:0] p2_wins;
   logic [6:0] secs_left;
   logic [1:0] round_winner;
   logic [1:0] match_winner;

   int checks = 0;
   int errors = 0;

   // Model: phase 0..5, elapsed fight cycles and elapsed hold cycles.
   int m_ph, m_round, m_p1w, m_p2w, m_rw, m_mw, m_fc, m_ec, m_secs;
   int cd_cnt, cd_len;
   int mode_tab [1:3];
   int ko_tab   [1:3];
   bit want_start;
   bit noise_en;

   round_controller #(
      .ROUND_SECS     (RS),
      .FRAMES_PER_SEC (FPS),
      .WINS_NEEDED    (WN),
      .MAX_ROUNDS     (MR),
      .END_FRAMES     (EF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cd_active    (cd_active),
      .p1_ko        (p1_ko),
      .p2_ko        (p2_ko),
      .cd_start     (cd_start),
      .phase        (phase),
      .fight_en     (fight_en),
      .round_num    (round_num),
      .p1_wins      (p1_wins),
      .p2_wins      (p2_wins),
      .secs_left    (secs_left),
      .round_winner (round_winner),
      .match_winner (match_winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int winner_of(input int a, input int b);
      if (a > b) return 1;
      if (b > a) return 2;
      return 3;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_round = 1; m_p1w = 0; m_p2w = 0; m_rw = 0; m_mw = 0;
      m_fc = 0; m_ec = 0; m_secs = RS; cd_cnt = 0;
   endtask

   task automatic model_step(input bit s, input bit cda, input bit k1, input bit k2);
      int old;
      old = m_ph;
      case (old)
         0: if (s) m_ph = 1;
         1: m_ph = 2;
         2: if (!cda) begin m_ph = 3; m_fc = 0; m_secs = RS; end
         3: begin
            m_fc++;
            m_secs = RS - m_fc / FPS;
            if (m_secs < 0) m_secs = 0;
            if (k1 && k2) begin m_rw = 3; m_ph = 4; end
            else if (k1) begin m_p2w = (m_p2w < 3) ? m_p2w + 1 : 3; m_rw = 2; m_ph = 4; end
            else if (k2) begin m_p1w = (m_p1w < 3) ? m_p1w + 1 : 3; m_rw = 1; m_ph = 4; end
            else if (m_fc == RS * FPS) begin m_rw = 3; m_ph = 4; end
            if (m_ph == 4) m_ec = 0;
         end
         4: begin
            m_ec++;
            if (m_ec == EF) begin
               if (m_p1w == WN || m_p2w == WN || m_round == MR) begin
                  m_ph = 5;
                  m_mw = winner_of(m_p1w, m_p2w);
               end else begin
                  m_round++;
                  m_ph = 1;
               end
            end
         end
         5: if (s) begin
            m_ph = 0; m_round = 1; m_p1w = 0; m_p2w = 0; m_rw = 0; m_mw = 0;
         end
         default: m_ph = 0;
      endcase
      if (old == 1) cd_cnt = 0;
      else if (old == 2) cd_cnt++;
   endtask

   task automatic check_all();
      chk("phase",        32'(phase),        32'(m_ph));
      chk("cd_start",     32'(cd_start),     32'(m_ph == 1));
      chk("fight_en",     32'(fight_en),     32'(m_ph == 3));
      chk("round_num",    32'(round_num),    32'(m_round));
      chk("p1_wins",      32'(p1_wins),      32'(m_p1w));
      chk("p2_wins",      32'(p2_wins),      32'(m_p2w));
      chk("secs_left",    32'(secs_left),    32'(m_secs));
      chk("round_winner", 32'(round_winner), 32'(m_rw));
      chk("match_winner", 32'(match_winner), 32'(m_mw));
   endtask

   // One clock: choose inputs from the model's view of the current phase.
   task automatic tick();
      bit s, cda, k1, k2;
      s = 0; cda = 0; k1 = 0; k2 = 0;
      if (m_ph == 0 || m_ph == 5) s = want_start;
      else s = noise_en && ($urandom % 6 == 0);
      if (m_ph == 2) cda = (cd_cnt < cd_len);
      else cda = noise_en && ($urandom % 3 == 0);
      if (m_ph == 3) begin
         if (m_fc == ko_tab[m_round]) begin
            case (mode_tab[m_round])
               0: k2 = 1;
               1: k1 = 1;
               2: begin k1 = 1; k2 = 1; end
               default: ;
            endcase
         end
      end else if (noise_en) begin
         k1 = ($urandom % 5 == 0);
         k2 = ($urandom % 5 == 0);
      end
      start = s; cd_active = cda; p1_ko = k1; p2_ko = k2;
      @(posedge clk);
      if (reset) model_reset();
      else model_step(s, cda, k1, k2);
      #1;
      check_all();
   endtask

   task automatic run_until(input int ph, input int budget);
      int n;
      n = 0;
      while (m_ph != ph && n < budget) begin
         tick();
         n++;
      end
      chk("wait_phase", 32'(phase), 32'(ph));
   endtask

   task automatic pulse_start();
      want_start = 1;
      tick();
      want_start = 0;
   endtask

   task automatic apply_reset();
      reset = 1;
      #1;
      model_reset();
      check_all();
      tick();
      tick();
      reset = 0;
      tick();
   endtask

   task automatic set_rounds(input int a, input int ka, input int b, input int kb,
                             input int c, input int kc);
      mode_tab[1] = a; ko_tab[1] = ka;
      mode_tab[2] = b; ko_tab[2] = kb;
      mode_tab[3] = c; ko_tab[3] = kc;
   endtask

   task automatic play_match(input int exp_mw, input int exp_round);
      pulse_start();
      run_until(5, 20000);
      chk("match_winner_end", 32'(match_winner), 32'(exp_mw));
      chk("final_round",      32'(round_num),    32'(exp_round));
      repeat (3) tick();
      pulse_start();
      chk("menu_phase", 32'(phase),   32'(0));
      chk("menu_p1w",   32'(p1_wins), 32'(0));
      chk("menu_p2w",   32'(p2_wins), 32'(0));
      chk("menu_round", 32'(round_num), 32'(1));
      repeat (2) tick();
   endtask

   // Independent tally of a match from its per-round results.
   task automatic expect_match(input int a, input int b, input int c,
                               output int mw, output int rnd);
      int p1, p2, md;
      p1 = 0; p2 = 0; rnd = 3;
      for (int r = 1; r <= 3; r++) begin
         md = (r == 1) ? a : (r == 2) ? b : c;
         if (md == 0) p1++;
         else if (md == 1) p2++;
         if (p1 == WN || p2 == WN || r == MR) begin
            rnd = r;
            break;
         end
      end
      mw = (p1 > p2) ? 1 : (p2 > p1) ? 2 : 3;
   endtask

   initial begin
      int emw, ern, a, b, c;
      start = 0; cd_active = 0; p1_ko = 0; p2_ko = 0;
      want_start = 0; noise_en = 0; cd_len = 120;
      set_rounds(3, -1, 3, -1, 3, -1);
      reset = 1;
      apply_reset();
      chk("reset_secs", 32'(secs_left), 32'(60));

      // P1 wins two rounds by p2 KOs.
      noise_en = 1;
      set_rounds(0, $urandom_range(300, 0), 0, $urandom_range(300, 0), 3, -1);
      play_match(1, 2);

      // Timeout draw, double KO draw, then P2 takes round 3.
      cd_len = $urandom_range(150, 1);
      set_rounds(3, -1, 2, $urandom_range(200, 0), 1, $urandom_range(200, 0));
      play_match(2, 3);

      // Three double-KO draws.
      set_rounds(2, $urandom_range(100, 0), 2, 0, 2, $urandom_range(100, 0));
      play_match(3, 3);

      // KO on the very cycle the last second expires.
      cd_len = $urandom_range(150, 1);
      set_rounds(1, RS * FPS - 1, 0, $urandom_range(200, 0), 2, $urandom_range(50, 0));
      play_match(3, 3);

      // Random non-timeout matches.
      for (int i = 0; i < 4; i++) begin
         a = $urandom % 3; b = $urandom % 3; c = $urandom % 3;
         cd_len = $urandom_range(150, 1);
         set_rounds(a, $urandom_range(400, 0), b, $urandom_range(400, 0),
                    c, $urandom_range(400, 0));
         expect_match(a, b, c, emw, ern);
         play_match(emw, ern);
      end

      // Reset mid-FIGHT.
      set_rounds(0, 1000, 0, 1000, 0, 1000);
      pulse_start();
      run_until(3, 1000);
      repeat (20) tick();
      apply_reset();
      chk("rst_fight_phase", 32'(phase), 32'(0));

      // Reset mid-ROUND_END.
      set_rounds(1, 10, 1, 10, 1, 10);
      pulse_start();
      run_until(4, 1000);
      repeat (30) tick();
      apply_reset();
      chk("rst_end_secs", 32'(secs_left), 32'(60));
      chk("rst_end_p2w",  32'(p2_wins),   32'(0));
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
